btn_pattern_recorder: RTL and testbench
=======================================

Name: btn_pattern_recorder

Overview:
Captures a WIDTH-bit button/switch pattern into an on-chip sample memory at a slow, prescaled rate. It is the writer counterpart of the LED pattern player, which reads the same memory format out to the LEDs. The block runs in a single clock domain. It uses a one-cycle tick enable, not a derived clock. A registered read port lets the player, or any other consumer, fetch recorded samples.

Parameters:
WIDTH, 5, bits per sample (matches LED width)
DEPTH, 16, number of sample slots
ADDR_W, 4, address width; must equal clog2(DEPTH)
DIV_BITS, 21, prescaler width; one sample tick every 2^DIV_BITS clocks

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-low reset
BTN  in  WIDTH  raw asynchronous button inputs
START  in  1  single-cycle request to begin recording (synchronous to CLK)
STOP  in  1  single-cycle request to end recording (synchronous to CLK)
RD_ADDR  in  ADDR_W  read address
RD_DATA  out  WIDTH  registered read data
COUNT  out  ADDR_W+1  number of valid samples written, range 0..DEPTH
BUSY  out  1  high while recording
FULL  out  1  high once DEPTH samples are stored

Behaviour:
- Reset (RESET=0 at a CLK edge):
  - state goes to IDLE.
  - COUNT, write pointer, prescaler, both synchroniser stages and RD_DATA all go to 0.
  - BUSY and FULL go to 0.
  - Memory contents are NOT cleared.
- Input sync: BTN passes through a 2-flop synchroniser. "sample" means the second stage.
- Prescaler: a DIV_BITS-bit counter that runs freely and wraps. tick is high for one cycle when the counter equals all-ones. The counter clears to 0 on any accepted START. As a result, the first write lands on the 2^DIV_BITS-th edge after the START edge.
- FSM states are IDLE, RECORD and FULL. STOP has priority over START in every state.
  - IDLE: START and not STOP -> RECORD. On entry, write pointer, COUNT and prescaler all go to 0.
  - RECORD, on tick: MEM[wptr] <= sample, wptr++, COUNT++. If this write makes COUNT equal DEPTH, go to FULL.
  - RECORD with STOP: go to IDLE and keep COUNT. If STOP and tick arrive in the same cycle, the sample is written and COUNT increments first; the next state is still IDLE.
  - RECORD with START: ignored.
  - FULL: no writes. START -> RECORD (fresh restart, COUNT 0). STOP -> IDLE, keeping COUNT=DEPTH.
- Write pointer wraps mod DEPTH. It can never overrun, because FULL stops writes.
- Outputs: BUSY = (state==RECORD). FULL = (state==FULL). Both are registered state decodes.
- Read port: RD_DATA <= MEM[RD_ADDR] every cycle, with 1-cycle latency and no enable.
  - Read and write to the same address in the same cycle: RD_DATA returns the old data (read-before-write).
  - Addresses >= COUNT return whatever is stored; this is not an error.
- Reset mid-recording aborts the recording (IDLE, COUNT=0). Samples already written remain readable.
- Memory must infer block/distributed RAM: one write port, one registered read port, no reset on the array.

Decomposition:
- Shared package/header holds:
  - the state encoding constants (IDLE=2'd0, RECORD=2'd1, FULL=2'd2);
  - default WIDTH and DEPTH values, shared with the LED pattern player.
- One sub-module: tick_gen. It contains the DIV_BITS counter with a synchronous clear input and produces the one-cycle tick output. It is reusable by the player to replace derived-clock division.
- The synchroniser, FSM and RAM stay inline.

Test Plan:
All scenarios use DIV_BITS=2, DEPTH=4, WIDTH=5.
1. Reset: hold RESET=0 for 2 cycles -> BUSY=0, FULL=0, COUNT=0, RD_DATA=0. Hold RESET=1 with no START -> state stays IDLE and COUNT stays 0 for 20 cycles.
2. Fill with a constant: BTN=5'b00011 stable 3+ cycles, then START pulse -> first write on the 4th edge after START, COUNT=1 the cycle after. Subsequent writes every 4 cycles. COUNT=4 and FULL=1 with BUSY=0 after the 16th edge. No further writes afterwards.
3. Pattern capture and readback: BTN changes between ticks through 1, 2, 4, 8, fill to FULL. Then RD_ADDR=0,1,2,3 on consecutive cycles -> RD_DATA=1,2,4,8, each one cycle after its address.
4. STOP mid-record: STOP one cycle after the 2nd write -> COUNT=2, BUSY=0. 12 more cycles -> COUNT still 2 and address 2 keeps its previous content.
5. Simultaneous events:
   - STOP in the tick cycle -> that sample is stored, COUNT increments, state is IDLE.
   - START+STOP together in IDLE -> remains IDLE.
   - START while RECORD -> COUNT not reset.
6. Reset mid-record: COUNT=2, then RESET=0 for 1 cycle -> IDLE, COUNT=0. Reading address 0 afterwards returns the sample recorded before reset.

Source files
------------

// File: rtl/btn_pattern_recorder_pkg.sv
// Shared definitions for the button pattern recorder and the LED pattern player.
package btn_pattern_recorder_pkg;

  localparam int unsigned DefaultWidth = 5;
  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StFull   = 2'd2
  } state_e;

endpackage

// File: rtl/btn_pattern_recorder_tick_gen.sv
// Free-running prescaler producing a one-cycle tick when the counter is all-ones.
module btn_pattern_recorder_tick_gen #(
  parameter int unsigned DIV_BITS = 21
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = &cnt_q;

endmodule

// File: rtl/btn_pattern_recorder.sv
// Records synchronised button samples into a small RAM at the prescaled tick rate.
module btn_pattern_recorder
  import btn_pattern_recorder_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DIV_BITS = 21
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  BTN,
  input  logic              START,
  input  logic              STOP,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic [ADDR_W:0]   COUNT,
  output logic              BUSY,
  output logic              FULL
);

  localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [WIDTH-1:0]    sync1_q, sync2_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                tick, presc_clr, we;

  btn_pattern_recorder_tick_gen #(
    .DIV_BITS (DIV_BITS)
  ) u_tick_gen (
    .clk_i  (CLK),
    .rst_ni (RESET),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    we        = 1'b0;
    presc_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START && !STOP) begin
          state_d   = StRecord;
          wptr_d    = '0;
          count_d   = '0;
          presc_clr = 1'b1;
        end
      end
      StRecord: begin
        // A tick coinciding with STOP still stores its sample.
        if (tick) begin
          we      = 1'b1;
          wptr_d  = wptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LastCount) begin
            state_d = StFull;
          end
        end
        if (STOP) begin
          state_d = StIdle;
        end
      end
      StFull: begin
        if (STOP) begin
          state_d = StIdle;
        end else if (START) begin
          state_d   = StRecord;
          wptr_d    = '0;
          count_d   = '0;
          presc_clr = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      count_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      sync1_q <= BTN;
      sync2_q <= sync1_q;
    end
  end

  // Sample storage carries no reset so it maps onto RAM primitives.
  always_ff @(posedge CLK) begin
    if (we && RESET) begin
      mem_q[wptr_q] <= sync2_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[RD_ADDR];
    end
  end

  assign RD_DATA = rd_data_q;
  assign COUNT   = count_q;
  assign BUSY    = (state_q == StRecord);
  assign FULL    = (state_q == StFull);

endmodule

// File: tb/tb_btn_pattern_recorder.sv
// Self-checking bench for btn_pattern_recorder with DEPTH=4, DIV_BITS=2, WIDTH=5.
module tb_btn_pattern_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] rd_addr = '0;
  logic [4:0] rd_data;
  logic [2:0] count;
  logic       busy, full;

  int checks = 0;
  int failures = 0;

  btn_pattern_recorder #(
    .WIDTH    (5),
    .DEPTH    (4),
    .ADDR_W   (2),
    .DIV_BITS (2)
  ) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .BTN     (btn),
    .START   (start),
    .STOP    (stop),
    .RD_ADDR (rd_addr),
    .RD_DATA (rd_data),
    .COUNT   (count),
    .BUSY    (busy),
    .FULL    (full)
  );

  always #5 clk = ~clk;

  // Reference model: recording/full flags, sample count (also the next write slot),
  // phase of the 4-clock prescaler and the two-edge input delay.
  int         m_count = 0;
  bit         m_rec = 0, m_full = 0;
  int         m_phase = 0;
  logic [4:0] m_s1 = '0, m_s2 = '0;
  logic [4:0] m_mem [4];
  bit         m_known [4] = '{0, 0, 0, 0};
  logic [4:0] m_rd = '0;
  bit         m_rd_known = 0;

  function automatic void model_edge();
    int         np;
    bit         tick;
    logic [4:0] smp;
    if (!rst_n) begin
      m_count = 0; m_rec = 0; m_full = 0; m_phase = 0;
      m_s1 = '0; m_s2 = '0; m_rd = '0; m_rd_known = 1;
      return;
    end
    m_rd       = m_mem[rd_addr];
    m_rd_known = m_known[rd_addr];
    tick = (m_phase == 3);
    np   = (m_phase + 1) % 4;
    smp  = m_s2;
    m_s2 = m_s1;
    m_s1 = btn;
    if (m_rec) begin
      if (tick) begin
        m_mem[m_count % 4]   = smp;
        m_known[m_count % 4] = 1;
        m_count++;
      end
      if (stop) m_rec = 0;
      else if (m_count == 4) begin
        m_rec = 0;
        m_full = 1;
      end
    end else if (stop) begin
      m_full = 0;
    end else if (start) begin
      m_rec = 1; m_full = 0; m_count = 0; np = 0;
    end
    m_phase = np;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_busy", 32'(busy), 32'(m_rec));
    chk("model_full", 32'(full), 32'(m_full));
    if (m_rd_known) chk("model_rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  typedef struct {
    int         edges;
    logic [2:0] count;
    logic       busy;
    logic       full;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int e;
    logic [4:0] pat [4];
    tbl[0] = '{3, 3'd0, 1'b1, 1'b0};
    tbl[1] = '{4, 3'd1, 1'b1, 1'b0};
    tbl[2] = '{7, 3'd1, 1'b1, 1'b0};
    tbl[3] = '{8, 3'd2, 1'b1, 1'b0};
    tbl[4] = '{12, 3'd3, 1'b1, 1'b0};
    tbl[5] = '{15, 3'd3, 1'b1, 1'b0};
    tbl[6] = '{16, 3'd4, 1'b0, 1'b1};
    tbl[7] = '{30, 3'd4, 1'b0, 1'b1};
    pat[0] = 5'd1; pat[1] = 5'd2; pat[2] = 5'd4; pat[3] = 5'd8;

    // Reset and idle hold
    #1;
    run(2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    run(20);
    chk("idle_count", 32'(count), 0);
    chk("idle_busy", 32'(busy), 0);

    // Constant fill, checked against the timing table
    btn = 5'b00011;
    run(3);
    pulse_start();
    e = 0;
    for (int i = 0; i < 8; i++) begin
      while (e < tbl[i].edges) begin
        cycle();
        e++;
      end
      chk($sformatf("fill_count[%0d]", i), 32'(count), 32'(tbl[i].count));
      chk($sformatf("fill_busy[%0d]", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("fill_full[%0d]", i), 32'(full), 32'(tbl[i].full));
    end
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      cycle();
      chk($sformatf("fill_rd[%0d]", a), 32'(rd_data), 32'd3);
    end

    // Pattern capture from FULL and readback
    btn = pat[0];
    run(3);
    pulse_start();
    for (int i = 1; i < 4; i++) begin
      run(4);
      btn = pat[i];
    end
    run(4);
    chk("pat_full", 32'(full), 1);
    chk("pat_count", 32'(count), 4);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      cycle();
      chk($sformatf("pat_rd[%0d]", a), 32'(rd_data), 32'(pat[a]));
    end

    // STOP one cycle after the second write
    btn = 5'h1f;
    run(3);
    pulse_start();
    run(8);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_count", 32'(count), 2);
    chk("stop_busy", 32'(busy), 0);
    run(12);
    chk("stop_count_hold", 32'(count), 2);
    rd_addr = 2'd2;
    cycle();
    chk("stop_rd2", 32'(rd_data), 32'd4);

    // STOP in the tick cycle
    btn = 5'h15;
    pulse_start();
    run(3);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stoptick_count", 32'(count), 1);
    chk("stoptick_busy", 32'(busy), 0);
    chk("stoptick_full", 32'(full), 0);
    rd_addr = 2'd0;
    cycle();
    chk("stoptick_rd0", 32'(rd_data), 32'h15);

    // START with STOP in IDLE
    start = 1'b1;
    stop = 1'b1;
    cycle();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", 32'(busy), 0);
    chk("startstop_count", 32'(count), 1);

    // START while recording is ignored, prescaler keeps running
    btn = 5'h0a;
    pulse_start();
    run(3);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(3);
    chk("rec_start_count1", 32'(count), 1);
    cycle();
    chk("rec_start_count2", 32'(count), 2);
    chk("rec_start_busy", 32'(busy), 1);

    // Reset mid-record
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_busy", 32'(busy), 0);
    rd_addr = 2'd0;
    cycle();
    chk("midrst_rd0", 32'(rd_data), 32'h0a);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      btn     = 5'($urandom);
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 15) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      rd_addr = 2'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
